dtw_mem_bank: RTL

Parametrised synchronous single-port memory bank for the DTW datapath, the next generation of the bench-side 1024×32 memory model. It adds configurable width, depth and read latency, byte-enabled writes, bus-conflict detection, and a hardware dump engine. The dump engine streams a contiguous address window out over a valid/ready port, so result checking no longer needs back-door array access. It sits on the TOP memory bus (CS/WR/addr/dbus) and feeds the result checker or a host link through the dump port.

---
 rtl/dtw_mem_bank_if.sv | 25 ++
 rtl/dtw_mem_bank.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/dtw_mem_bank_if.sv
// Dump port of the DTW memory bank: start/parameters in, valid/ready word stream out.
// The consumer side uses the master modport; the bank uses the slave modport.
interface dtw_mem_bank_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 10
);
    logic              i_dump_start;
    logic [ADDR_W-1:0] i_dump_base;
    logic [ADDR_W:0]   i_dump_len;
    logic [DATA_W-1:0] o_dump_data;
    logic              o_dump_valid;
    logic              i_dump_ready;
    logic              o_dump_busy;
    logic              o_dump_done;

    modport master (
        output i_dump_start, i_dump_base, i_dump_len, i_dump_ready,
        input  o_dump_data, o_dump_valid, o_dump_busy, o_dump_done
    );

    modport slave (
        input  i_dump_start, i_dump_base, i_dump_len, i_dump_ready,
        output o_dump_data, o_dump_valid, o_dump_busy, o_dump_done
    );
endinterface

// File: rtl/dtw_mem_bank.sv
// Single-port DTW memory bank: byte-enabled host writes, RD_LAT-cycle host reads on a shared
// tristate bus, sticky bus-conflict flag, and a background dump engine feeding a small FIFO.
module dtw_mem_bank #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned RD_LAT    = 1,
    parameter int unsigned DUMP_FIFO = 4
) (
    input  logic                i_clk,
    input  logic                i_nrst,
    input  logic                i_CS,
    input  logic                i_WR,
    input  logic [ADDR_W-1:0]   i_addr,
    input  logic [DATA_W/8-1:0] i_be,
    inout  wire  [DATA_W-1:0]   dbus,
    output logic                o_bus_err,
    dtw_mem_bank_if.slave       dump
);
    localparam int unsigned NB    = DATA_W / 8;
    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam int unsigned FW    = $clog2(DUMP_FIFO + 1);
    localparam int unsigned PW    = (DUMP_FIFO > 1) ? $clog2(DUMP_FIFO) : 1;

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

    logic [DATA_W-1:0] mem_q [DEPTH];

    state_e            state_q;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W:0]   len_q, idx_q;
    logic              busy_q, done_q, err_q;

    logic [RD_LAT-1:0] pv_host_q, pv_dump_q;
    logic [DATA_W-1:0] pd_q [RD_LAT];
    logic [FW-1:0]     inflight_q, cnt_q;
    logic [DATA_W-1:0] fifo_q [DUMP_FIFO];
    logic [PW-1:0]     wptr_q, rptr_q;

    logic              host_rd, host_wr, push, pop, credit_ok, issue, dbus_oe;
    logic [31:0]       credits_used;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_word;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DUMP_FIFO - 1)) ? '0 : p + 1'b1;
    endfunction

    assign host_rd = !i_CS && !i_WR;
    assign host_wr = !i_CS && i_WR;
    assign push    = pv_dump_q[RD_LAT-1];
    assign pop     = (cnt_q != '0) && dump.i_dump_ready;

    // A pop at this edge frees its slot at the same edge, so it counts as a returned credit.
    assign credits_used = 32'(inflight_q) + 32'(cnt_q) - 32'(pop);
    assign credit_ok    = credits_used < DUMP_FIFO;
    assign issue        = (state_q == StRun) && i_CS && (idx_q < len_q) && credit_ok;

    assign rd_addr = host_rd ? i_addr : base_q + idx_q[ADDR_W-1:0];
    assign rd_word = mem_q[rd_addr];

    // On a conflict the host owns the bus; the bank backs off for that cycle.
    assign dbus_oe = pv_host_q[RD_LAT-1] && !host_wr;
    assign dbus    = dbus_oe ? pd_q[RD_LAT-1] : {DATA_W{1'bz}};

    assign o_bus_err         = err_q;
    assign dump.o_dump_data  = fifo_q[rptr_q];
    assign dump.o_dump_valid = (cnt_q != '0);
    assign dump.o_dump_busy  = busy_q;
    assign dump.o_dump_done  = done_q;

    always_ff @(posedge i_clk) begin
        if (host_wr) begin
            for (int b = 0; b < NB; b++) begin
                if (i_be[b]) mem_q[i_addr][8*b +: 8] <= dbus[8*b +: 8];
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            pv_host_q  <= '0;
            pv_dump_q  <= '0;
            inflight_q <= '0;
            err_q      <= 1'b0;
            for (int i = 0; i < RD_LAT; i++) pd_q[i] <= '0;
        end else begin
            pv_host_q[0] <= host_rd;
            pv_dump_q[0] <= issue;
            pd_q[0]      <= rd_word;
            for (int i = 1; i < RD_LAT; i++) begin
                pv_host_q[i] <= pv_host_q[i-1];
                pv_dump_q[i] <= pv_dump_q[i-1];
                pd_q[i]      <= pd_q[i-1];
            end
            inflight_q <= inflight_q + FW'(issue) - FW'(push);
            if (pv_host_q[RD_LAT-1] && host_wr) err_q <= 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
            for (int i = 0; i < DUMP_FIFO; i++) fifo_q[i] <= '0;
        end else begin
            if (push) begin
                fifo_q[wptr_q] <= pd_q[RD_LAT-1];
                wptr_q         <= ptr_inc(wptr_q);
            end
            if (pop) rptr_q <= ptr_inc(rptr_q);
            cnt_q <= cnt_q + FW'(push) - FW'(pop);
        end
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state_q <= StIdle;
            base_q  <= '0;
            len_q   <= '0;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (dump.i_dump_start) begin
                        base_q <= dump.i_dump_base;
                        len_q  <= dump.i_dump_len;
                        idx_q  <= '0;
                        busy_q <= 1'b1;
                        if (dump.i_dump_len == '0) begin
                            state_q <= StDone;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= StRun;
                        end
                    end
                end
                StRun: begin
                    if (issue) begin
                        idx_q <= idx_q + 1'b1;
                        if ((idx_q + 1'b1) == len_q) state_q <= StDrain;
                    end
                end
                StDrain: begin
                    // Finish as soon as the last word leaves, so done follows its acceptance.
                    if (inflight_q == '0 && (cnt_q == '0 || (cnt_q == FW'(1) && pop))) begin
                        state_q <= StDone;
                        done_q  <= 1'b1;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
                default: state_q <= StIdle;
            endcase
        end
    end
endmodule
